// File: rtl/gtx_prbs_pkg.sv
// rtl/gtx_prbs_pkg.sv - shared PRBS-24 [24,23,22,17] next-word function, state encoding and seed
// Generator and checker both take F from here so the two ends cannot diverge.
package gtx_prbs_pkg;

  localparam logic [23:0] PRBS_SEED = 24'h4DB62E;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // One CE advances the Fibonacci LFSR 24 bit-times, so every word is fully new bits.
  function automatic logic [23:0] lfsr_r24_next(input logic [23:0] x);
    logic [23:0] s;
    s = x;
    for (int i = 0; i < 24; i++) begin
      s = {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
    end
    return s;
  endfunction

endpackage

// File: rtl/gtx_sat_cnt.sv
// rtl/gtx_sat_cnt.sv - saturating counter with synchronous clear and multi-bit increment
// A clear in the same cycle as an increment loads the increment rather than zero.
module gtx_sat_cnt #(
  parameter int W  = 16,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [IW-1:0] inc,
  output logic [W-1:0]  cnt
);

  localparam int SW = ((W > IW) ? W : IW) + 1;
  localparam logic [SW-1:0] MAXV = SW'({W{1'b1}});

  logic [SW-1:0] base;
  logic [SW-1:0] sum;

  always_comb begin
    base = clr ? '0 : SW'(cnt);
    sum  = base + SW'(inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= (sum > MAXV) ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/gtx_prbs_chk_r24_c160.sv
// rtl/gtx_prbs_chk_r24_c160.sv - self-synchronising PRBS-24 link-test checker with flywheel lock
// Optional bit-error counter enabled by macro GTX_PRBS_BIT_ERR_CNT_EN.
module gtx_prbs_chk_r24_c160
  import gtx_prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [23:0]      data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             lock_lost
`ifdef GTX_PRBS_BIT_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] bit_err_cnt
`endif
);

  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

  chk_state_t  state_q, state_d;
  logic [23:0] ref_q, ref_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic        locked_d;
  logic        err_d;
  logic        lost_d;
  logic        lost_set;
  logic        err_inc;
  logic [23:0] exp_word;
  logic        hit;

  assign exp_word = lfsr_r24_next(ref_q);
  assign hit      = (data == exp_word);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked;
    err_d    = 1'b0;
    lost_set = 1'b0;
    err_inc  = 1'b0;
    if (ce) begin
      case (state_q)
        HUNT: begin
          // An all-zero stream is a fixed point of F and must never lock.
          if (data != 24'd0) begin
            ref_d   = data;
            match_d = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          ref_d = data;
          if (hit) begin
            match_d = match_q + 4'd1;
            if (match_q == LOCK_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = 4'd0;
            end
          end else begin
            match_d = 4'd0;
            if (data == 24'd0) state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the expected sequence never absorbs a corrupted word.
          ref_d = exp_word;
          if (hit) begin
            miss_d = 4'd0;
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            if (miss_q == UNLOCK_LAST) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              lost_set = 1'b1;
              miss_d   = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end
    lost_d = lost_set ? 1'b1 : (clr_cnt ? 1'b0 : lock_lost);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      ref_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= locked_d;
      err       <= err_d;
      lock_lost <= lost_d;
    end
  end

  gtx_sat_cnt #(.W(CNT_W), .IW(1)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );

`ifdef GTX_PRBS_BIT_ERR_CNT_EN
  logic [23:0] diff;
  logic [4:0]  bit_inc;

  assign diff = data ^ exp_word;

  always_comb begin
    bit_inc = 5'd0;
    if (ce && (state_q == LOCKED)) begin
      for (int i = 0; i < 24; i++) begin
        bit_inc = bit_inc + 5'(diff[i]);
      end
    end
  end

  gtx_sat_cnt #(.W(CNT_W), .IW(5)) u_bit_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (bit_inc),
    .cnt   (bit_err_cnt)
  );
`endif

endmodule

// File: tb/tb_gtx_prbs_chk_r24_c160.sv
// tb/tb_gtx_prbs_chk_r24_c160.sv - directed self-checking bench for the PRBS-24 checker
// Exercises GTX_PRBS_BIT_ERR_CNT_EN checks only when that macro is defined.
module tb_gtx_prbs_chk_r24_c160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [23:0] data;
  logic        clr_cnt;
  logic        locked, err, lock_lost;
  logic [15:0] err_cnt;
  logic        locked4, err4, lock_lost4;
  logic [3:0]  err_cnt4;
`ifdef GTX_PRBS_BIT_ERR_CNT_EN
  logic [15:0] bit_err_cnt;
  logic [3:0]  bit_err_cnt4;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] gen;

  always #5 clk = ~clk;

  gtx_prbs_chk_r24_c160 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .data      (data),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .lock_lost (lock_lost)
`ifdef GTX_PRBS_BIT_ERR_CNT_EN
    ,
    .bit_err_cnt (bit_err_cnt)
`endif
  );

  gtx_prbs_chk_r24_c160 #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .data      (data),
    .clr_cnt   (clr_cnt),
    .locked    (locked4),
    .err       (err4),
    .err_cnt   (err_cnt4),
    .lock_lost (lock_lost4)
`ifdef GTX_PRBS_BIT_ERR_CNT_EN
    ,
    .bit_err_cnt (bit_err_cnt4)
`endif
  );

  // Independent reference: tap mask for x^24+x^23+x^22+x^17, 24 shifts per word.
  function automatic logic [23:0] ref_next(input logic [23:0] x);
    logic [23:0] s;
    s = x;
    repeat (24) s = {s[22:0], ^(s & 24'hE10000)};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic [23:0] d, input logic clr);
    ce      = c;
    data    = d;
    clr_cnt = clr;
    @(posedge clk);
    #1;
    ce      = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic send(input logic [23:0] mask, input logic clr);
    step(1'b1, gen ^ mask, clr);
    gen = ref_next(gen);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic lock_from_hunt(input string tag, input logic toggle);
    for (int i = 1; i <= 9; i++) begin
      if (toggle) step(1'b0, 24'($urandom), 1'b0);
      send(24'd0, 1'b0);
      if (i == 8) chk({tag, "_not_yet"}, 32'(locked), 32'd0);
      if (i == 9) chk({tag, "_locked"}, 32'(locked), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; data = '0; clr_cnt = 1'b0;
    gen = gtx_prbs_pkg::PRBS_SEED;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(1'b1, 24'd0, 1'b0);
      chk("zero_locked", 32'(locked), 32'd0);
    end

    lock_from_hunt("clean", 1'b0);
    repeat (991) send(24'd0, 1'b0);
    chk("clean_1000_err_cnt", 32'(err_cnt), 32'd0);
    chk("clean_1000_locked", 32'(locked), 32'd1);

    do_reset();
    gen = gtx_prbs_pkg::PRBS_SEED;
    lock_from_hunt("toggle", 1'b1);
    step(1'b0, 24'hFFFFFF, 1'b0);
    chk("ce_low_err", 32'(err), 32'd0);
    chk("ce_low_locked", 32'(locked), 32'd1);

    send(24'h000001, 1'b0);
    chk("single_err", 32'(err), 32'd1);
    chk("single_err_cnt", 32'(err_cnt), 32'd1);
    chk("single_locked", 32'(locked), 32'd1);
`ifdef GTX_PRBS_BIT_ERR_CNT_EN
    chk("single_bit_err_cnt", 32'(bit_err_cnt), 32'd1);
`endif
    send(24'd0, 1'b0);
    chk("single_next_err", 32'(err), 32'd0);
    send(24'd0, 1'b0);
    chk("single_next2_err", 32'(err), 32'd0);
    chk("single_hold_cnt", 32'(err_cnt), 32'd1);

    send(24'd0, 1'b1);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    repeat (3) send(24'h000001, 1'b0);
    chk("three_err_cnt", 32'(err_cnt), 32'd3);
    chk("three_locked", 32'(locked), 32'd1);
    send(24'd0, 1'b0);
    repeat (3) send(24'h000001, 1'b0);
    chk("four_pre_locked", 32'(locked), 32'd1);
    send(24'h000001, 1'b0);
    chk("four_locked", 32'(locked), 32'd0);
    chk("four_lock_lost", 32'(lock_lost), 32'd1);
    chk("four_err_cnt", 32'(err_cnt), 32'd7);
    lock_from_hunt("relock", 1'b0);
    chk("relock_lock_lost", 32'(lock_lost), 32'd1);

    send(24'h800001, 1'b1);
    chk("clr_coinc_err_cnt", 32'(err_cnt), 32'd1);
    chk("clr_coinc_lock_lost", 32'(lock_lost), 32'd0);
`ifdef GTX_PRBS_BIT_ERR_CNT_EN
    chk("clr_coinc_bit_err_cnt", 32'(bit_err_cnt), 32'd2);
`endif

    send(24'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send(24'h000001, 1'b0);
      send(24'd0, 1'b0);
    end
    chk("sat_wide_err_cnt", 32'(err_cnt), 32'd20);
    chk("sat_narrow_err_cnt", 32'(err_cnt4), 32'hF);
    chk("sat_locked", 32'(locked), 32'd1);

    send(24'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(24'd0, 1'b0);
      send(24'h000001, 1'b0);
    end
    chk("mid_pre_err_cnt", 32'(err_cnt), 32'd5);
    chk("mid_pre_err", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_lock_lost", 32'(lock_lost), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lock_from_hunt("mid_relock", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gtx_prbs_chk_r24_c160.md
Name: gtx_prbs_chk_r24_c160

Overview:
- Receive-side checker for the 24-bit [24,23,22,17] parallel PRBS that the CFEB GTX link transmits during link test.
- Sits after the GTX RX word alignment and compares every received 24-bit word with the expected next word.
- Self-synchronises to the incoming stream, then free-runs (flywheels) once locked.
- Reports lock, per-word error pulses and saturating error counters to the link-status registers.

Parameters:
- LOCK_CNT, 8: consecutive matching words needed to declare lock (range 1..15).
- UNLOCK_CNT, 4: consecutive mismatching words while locked that drop lock (range 1..15).
- CNT_W, 16: width of the error counters.

Ports:
- CLK  in  1  link word clock.
- RST_N  in  1  asynchronous reset, active low.
- CE  in  1  DATA is a valid PRBS word this cycle.
- DATA  in  24  received word.
- CLR_CNT  in  1  synchronous clear of the counters and of LOCK_LOST.
- LOCKED  out  1  checker is locked.
- ERR  out  1  one-cycle pulse when a locked word mismatches.
- ERR_CNT  out  CNT_W  mismatching words while locked; saturates.
- LOCK_LOST  out  1  sticky; set on every LOCKED to HUNT transition.
- BIT_ERR_CNT  out  CNT_W  errored bits; present only with the optional feature.

Behaviour:
- Reset: RST_N low asynchronously clears state to HUNT. All outputs go to 0, and so do the internal ref, match_cnt and miss_cnt.
- F(x) is the 24-bit next-word function. It is bit-exact to the generator's per-CE update.
- CE low: every register holds its value and ERR is 0.
- Latency: ERR, LOCKED and the counters are registered and update on the clock edge that samples the CE word. They are visible the cycle after DATA is presented.

State machine (2-bit):
- HUNT, on CE:
  - If DATA is not 0: ref<=DATA, match_cnt<=0, go to VERIFY.
  - If DATA == 0: stay in HUNT. F(0)=0, so this rejects a false lock on an all-zero stream.
- VERIFY, on CE:
  - Always ref<=DATA (self-sync).
  - If DATA == F(ref): match_cnt++.
  - On the match that brings match_cnt to LOCK_CNT: go to LOCKED, LOCKED<=1, ref<=DATA, miss_cnt<=0.
  - On a mismatch: match_cnt<=0 and stay in VERIFY. If DATA == 0: go to HUNT.
- LOCKED, on CE:
  - Always ref<=F(ref) (flywheel). A corrupted word therefore never propagates into the expected sequence.
  - Match: miss_cnt<=0.
  - Mismatch: ERR<=1, ERR_CNT increments with saturation, miss_cnt++.
  - When miss_cnt reaches UNLOCK_CNT: go to HUNT, LOCKED<=0, LOCK_LOST<=1.
- Counters:
  - ERR_CNT saturates at all-ones.
  - CLR_CNT clears ERR_CNT, BIT_ERR_CNT and LOCK_LOST.
  - CLR_CNT in the same cycle as an error: the counter loads the current increment (ERR_CNT=1), not 0.
  - CLR_CNT in the same cycle as an unlock: LOCK_LOST=1, because the set wins.
- Counters only count while LOCKED; HUNT and VERIFY mismatches are not errors.
- Lock state is not affected by CLR_CNT.

Optional Feature:
- Macro: GTX_PRBS_BIT_ERR_CNT_EN.
- Defined:
  - Adds BIT_ERR_CNT, which adds popcount(DATA ^ F(ref)) on each locked CE.
  - The add saturates at all-ones.
  - The popcount stage is combinational into the registered adder; latency is unchanged.
- Undefined:
  - The port is absent and no popcount logic is built.
  - All other behaviour is identical.

Decomposition:
- Package gtx_prbs_pkg holds:
  - function lfsr_r24_next(x) (F);
  - the state encoding localparams HUNT=0, VERIFY=1, LOCKED=2;
  - the default seed 24'h4DB62E.
- Both the generator and this checker take F from this package, so they cannot diverge.
- One sub-module, gtx_sat_cnt (parameterised width, increment input, clear input, saturation), is instantiated for ERR_CNT and, optionally, BIT_ERR_CNT.

Test Plan:
- Reset:
  - Stimulus: hold RST_N low, then release.
  - Required: LOCKED=0, ERR=0, ERR_CNT=0, LOCK_LOST=0.
  - Stimulus: drive CE=1 with DATA=0 for 20 cycles.
  - Required: LOCKED stays 0 and the state stays HUNT.
- Clean lock:
  - Stimulus: stream the sequence starting at 24'h4DB62E with CE=1.
  - Required: LOCKED rises after the 9th word; ERR_CNT=0 after 1000 words.
  - Repeat with CE toggling every other cycle: identical lock point in word count.
- Single error:
  - Stimulus: while locked, invert DATA[0] of one word.
  - Required: one ERR pulse, ERR_CNT=1, BIT_ERR_CNT=1 if enabled, LOCKED stays 1.
  - Required: the next clean words give no ERR.
- Unlock and relock:
  - Stimulus: corrupt 3 consecutive words.
  - Required: ERR_CNT=3, LOCKED=1.
  - Stimulus: corrupt 4 consecutive words.
  - Required: LOCKED=0, LOCK_LOST=1, ERR_CNT=7.
  - Stimulus: resume clean words.
  - Required: relock after 9 words; LOCK_LOST stays 1.
- Clear and saturation:
  - Stimulus: CLR_CNT coincident with an error.
  - Required: ERR_CNT=1, LOCK_LOST=0.
  - Stimulus: with CNT_W=4, inject 20 isolated errors.
  - Required: ERR_CNT=4'hF.
- Mid-operation reset:
  - Stimulus: assert RST_N low while locked with ERR_CNT=5.
  - Required: all outputs go to 0 immediately.
  - Stimulus: release reset and stream clean data.
  - Required: relock after 9 words.
